// File: rtl/jit_pkg.sv
// rtl/jit_pkg.sv - opcodes, argument indices and FSM states shared by the command feeder
package jit_pkg;

    localparam logic [3:0] OP_GO  = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;
    localparam logic [3:0] OP_ARG = 4'hC;

    localparam logic [3:0] ARG_IDX_1 = 4'd1;
    localparam logic [3:0] ARG_IDX_2 = 4'd2;
    localparam logic [3:0] ARG_IDX_3 = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_ARG,
        ST_ARG_WAIT,
        ST_ISSUE_RUN,
        ST_RUN_WAIT
    } feeder_state_t;

    // Only argument slots 1..3 exist in the token; anything else is dropped.
    function automatic logic arg_idx_ok(input logic [3:0] idx);
        return (idx == ARG_IDX_1) || (idx == ARG_IDX_2) || (idx == ARG_IDX_3);
    endfunction

endpackage

// File: rtl/jit_cmd_fifo.sv
// rtl/jit_cmd_fifo.sv - show-ahead command word FIFO with occupancy output
module jit_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              wr_data,
    input  logic                     wr_en,
    output logic                     full,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_wr;
    logic        do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/jit_cmd_feeder.sv
// rtl/jit_cmd_feeder.sv - buffers host words and paces single-cycle cmd pulses to the JIT token
import jit_pkg::*;

module jit_cmd_feeder #(
    parameter int DEPTH   = 8,
    parameter int ARG_GAP = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [31:0]              s_cmd_data,
    input  logic                     s_cmd_valid,
    output logic                     s_cmd_ready,
    output logic [31:0]              cmd,
    input  logic                     done,
    output logic [27:0]              sw_cfg_data,
    output logic                     sw_cfg_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int GW = (ARG_GAP > 1) ? $clog2(ARG_GAP) : 1;

    feeder_state_t state;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign pop         = (state == ST_IDLE) && !fifo_empty;
    assign s_cmd_ready = !fifo_full;
    assign busy        = (state != ST_IDLE) || !fifo_empty;

    jit_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_data (s_cmd_data),
        .wr_en   (s_cmd_valid),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state        <= ST_IDLE;
            gap_cnt      <= '0;
            cmd          <= '0;
            sw_cfg_valid <= 1'b0;
            sw_cfg_data  <= '0;
            err          <= 1'b0;
        end else begin
            cmd          <= '0;
            sw_cfg_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head[31:28] == OP_GO) begin
                            cmd   <= head;
                            state <= ST_ISSUE_RUN;
                        end else if (head[31:28] == OP_ARG && arg_idx_ok(head[23:20])) begin
                            cmd   <= head;
                            state <= ST_ISSUE_ARG;
                        end else if (head[31:28] == OP_SW) begin
                            sw_cfg_valid <= 1'b1;
                            sw_cfg_data  <= head[27:0];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE_ARG: begin
                    gap_cnt <= GW'(ARG_GAP - 1);
                    state   <= ST_ARG_WAIT;
                end
                ST_ARG_WAIT: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                // done during the issue cycle belongs to an earlier run and is ignored
                ST_ISSUE_RUN: state <= ST_RUN_WAIT;
                ST_RUN_WAIT: begin
                    if (done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jit_cmd_feeder.sv
// tb/tb_jit_cmd_feeder.sv - directed self-checking bench for jit_cmd_feeder
module tb_jit_cmd_feeder;
    import jit_pkg::*;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [31:0] s_cmd_data;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [31:0] cmd;
    logic        done;
    logic [27:0] sw_cfg_data;
    logic        sw_cfg_valid;
    logic        busy;
    logic [3:0]  level;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int consec_viol = 0;
    logic prev_nz = 1'b0;
    logic [31:0] cmd_vals[$];
    int          cmd_cycs[$];
    logic [27:0] sw_vals[$];
    int          sw_cycs[$];

    jit_cmd_feeder dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .s_cmd_data   (s_cmd_data),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .cmd          (cmd),
        .done         (done),
        .sw_cfg_data  (sw_cfg_data),
        .sw_cfg_valid (sw_cfg_valid),
        .busy         (busy),
        .level        (level),
        .err          (err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(negedge ap_clk) begin
        cyc = cyc + 1;
        if (cmd != 32'h0) begin
            if (prev_nz) consec_viol = consec_viol + 1;
            cmd_vals.push_back(cmd);
            cmd_cycs.push_back(cyc);
        end
        prev_nz = (cmd != 32'h0);
        if (sw_cfg_valid) begin
            sw_vals.push_back(sw_cfg_data);
            sw_cycs.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        s_cmd_data  = w;
        s_cmd_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        s_cmd_valid = 1'b0;
        s_cmd_data  = 32'h0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    task automatic wait_cmds(input int n, input int budget);
        int k = 0;
        while (cmd_vals.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_cmds", cmd_vals.size(), n);
    endtask

    task automatic clear_logs();
        cmd_vals.delete();
        cmd_cycs.delete();
        sw_vals.delete();
        sw_cycs.delete();
    endtask

    initial begin
        int accepted;
        logic [3:0] max_level;
        ap_rst_n    = 1'b0;
        s_cmd_valid = 1'b0;
        s_cmd_data  = 32'h0;
        done        = 1'b0;
        #2;
        check("rst_cmd", cmd, 32'h0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_sw_valid", sw_cfg_valid, 0);
        check("rst_sw_data", sw_cfg_data, 0);
        tick(2);
        ap_rst_n = 1'b1;
        tick(1);
        check("rst_ready", s_cmd_ready, 1);

        // C, C, A sequence with a delayed done
        clear_logs();
        push_word(32'hC010_1234);
        push_word(32'hC020_0042);
        push_word(32'hA000_0000);
        wait_cmds(3, 40);
        check("seq_c1", cmd_vals[0], 32'hC010_1234);
        check("seq_c2", cmd_vals[1], 32'hC020_0042);
        check("seq_a", cmd_vals[2], 32'hA000_0000);
        check("arg_gap_1", (cmd_cycs[1] - cmd_cycs[0]) >= 2, 1);
        check("arg_gap_2", (cmd_cycs[2] - cmd_cycs[1]) >= 2, 1);
        tick(20);
        check("run_wait_quiet", cmd_vals.size(), 3);
        check("run_wait_busy", busy, 1);
        pulse_done();
        check("busy_after_done", busy, 0);

        // back-to-back switch-config words
        clear_logs();
        push_word(32'hB0AB_CDEF);
        push_word(32'hB000_0001);
        tick(5);
        check("sw_count", sw_vals.size(), 2);
        check("sw_data0", sw_vals[0], 28'h0AB_CDEF);
        check("sw_data1", sw_vals[1], 28'h000_0001);
        check("sw_back_to_back", sw_cycs[1] - sw_cycs[0], 1);
        check("sw_no_cmd", cmd_vals.size(), 0);

        // filtered words
        clear_logs();
        check("err_before", err, 0);
        push_word(32'hC000_0055);
        push_word(32'h0000_0000);
        push_word(32'hC030_0007);
        wait_cmds(1, 20);
        tick(3);
        check("err_after", err, 1);
        check("filter_count", cmd_vals.size(), 1);
        check("filter_val", cmd_vals[0], 32'hC030_0007);

        // done during ISSUE_RUN is ignored
        clear_logs();
        tick(3);
        push_word(32'hA000_0000);
        check("latency_t1", cmd, 32'h0);
        tick(1);
        check("latency_t2", cmd, 32'hA000_0000);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        push_word(32'hC010_0001);
        tick(5);
        check("early_done_busy", busy, 1);
        check("early_done_state", 32'(dut.state), 32'(ST_RUN_WAIT));
        check("early_done_no_issue", cmd_vals.size(), 1);
        check("early_done_level", level, 1);
        pulse_done();
        wait_cmds(2, 10);
        check("after_second_done", cmd_vals[1], 32'hC010_0001);

        // fill the FIFO behind a stalled Go
        tick(4);
        clear_logs();
        push_word(32'hA000_0000);
        wait_cmds(1, 10);
        tick(1);
        accepted    = 0;
        max_level   = '0;
        s_cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_cmd_data = 32'hC010_0000 | i;
            if (s_cmd_ready) accepted++;
            @(posedge ap_clk);
            #1;
            if (level > max_level) max_level = level;
        end
        s_cmd_valid = 1'b0;
        check("full_level", level, 8);
        check("full_ready", s_cmd_ready, 0);
        check("full_accepted", accepted, 8);
        check("full_max_level", max_level, 8);

        // asynchronous reset mid-RUN_WAIT with level 5
        ap_rst_n = 1'b0;
        tick(2);
        ap_rst_n = 1'b1;
        tick(1);
        check("rerst_level", level, 0);
        push_word(32'h0000_0000);
        push_word(32'hA000_0000);
        tick(3);
        for (int i = 0; i < 5; i++) push_word(32'hC020_0000 | i);
        check("pre_rst_level", level, 5);
        check("pre_rst_err", err, 1);
        check("pre_rst_state", 32'(dut.state), 32'(ST_RUN_WAIT));
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("async_cmd", cmd, 32'h0);
        check("async_level", level, 0);
        check("async_err", err, 0);
        check("async_busy", busy, 0);
        check("async_ready", s_cmd_ready, 1);
        tick(2);
        ap_rst_n = 1'b1;
        clear_logs();
        push_word(32'hC020_0099);
        check("post_rst_t1", cmd, 32'h0);
        tick(1);
        check("post_rst_t2", cmd, 32'hC020_0099);
        tick(4);
        check("cmd_single_cycle", consec_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jit_cmd_feeder.md
# jit_cmd_feeder

Command-issue stage that sits directly upstream of the JIT token block and drives its `cmd` input. Host command words are buffered in a small FIFO and presented one at a time as single-cycle pulses on `cmd`. Between pulses the stage paces itself to the token's state machine: a fixed gap after argument-setup words, and a wait for `done` after Go words. Switch-config words are diverted to a separate output. Words the token cannot handle are filtered out so they never reach `cmd`.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ARG_GAP`, 1: zero cycles on `cmd` after an opcode-C issue; minimum and default 1.

Ports:
- `ap_clk`  in  1  single clock.
- `ap_rst_n`  in  1  reset; asynchronous assert, active-low.
- `s_cmd_data`  in  32  host command word.
- `s_cmd_valid`  in  1  host word valid.
- `s_cmd_ready`  out  1  FIFO can accept a word; equals !full.
- `cmd`  out  32  word to the token; registered; 0 when idle.
- `done`  in  1  completion pulse from the token.
- `sw_cfg_data`  out  28  bits [27:0] of an opcode-B word.
- `sw_cfg_valid`  out  1  one-cycle strobe for `sw_cfg_data`.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err`  out  1  sticky: a word was dropped; cleared only by reset.

## Operation
- Push: a word is written when `s_cmd_valid && s_cmd_ready`.
  - A write while full is impossible because ready is low.
  - A push and a pop in the same cycle are both performed; `level` is unchanged.
- Filtering happens at pop, in IDLE. Words are classified by `[31:28]`:
  - `4'hA` (Go): copied to `cmd`, go to ISSUE_RUN.
  - `4'hC` (Set arg) with `[23:20]` in {1,2,3}: copied to `cmd`, go to ISSUE_ARG.
  - `4'hC` with any other index: dropped, `err` set, stay in IDLE.
  - `4'hB`: `sw_cfg_valid`=1 and `sw_cfg_data`=word[27:0] for one cycle; `cmd` stays 0; stay in IDLE.
  - All-zero word or any other opcode: dropped, `err` set.
- FSM states: IDLE, ISSUE_ARG, ARG_WAIT, ISSUE_RUN, RUN_WAIT.
  - IDLE: pops one word per cycle when the FIFO is not empty.
  - ISSUE_ARG: `cmd` holds the word for this cycle only; go to ARG_WAIT.
  - ARG_WAIT: `cmd`=0 for `ARG_GAP` cycles, counted by a down-counter; then go to IDLE.
  - ISSUE_RUN: `cmd` holds the word for this cycle only; go to RUN_WAIT. `done` is ignored in this cycle.
  - RUN_WAIT: `cmd`=0 until `done`=1; then go to IDLE. `done` in any other state is ignored.
- A `cmd` is never presented non-zero for more than one consecutive cycle.

## Timing
- Reset values: `cmd`=0, `sw_cfg_valid`=0, `sw_cfg_data`=0, `err`=0, `level`=0, `busy`=0, FIFO pointers 0, FSM in IDLE. `s_cmd_ready`=1 once reset is released.
- Reset asserted mid-operation (including RUN_WAIT) discards the FIFO contents and any in-flight wait immediately. The token is reset by the same `ap_rst_n`.
- Latency, empty FIFO to `cmd`: pushed at edge T, popped in IDLE in cycle T+1, `cmd` valid in cycle T+2.
- C→next issue: C on `cmd` in cycle N; next non-zero `cmd` no earlier than N+2 (ARG_GAP=1). This matches the token's ARG→FETCH return.
- A→next issue: `done` high in cycle D; next non-zero `cmd` no earlier than D+2.
- B throughput: one strobe per cycle for back-to-back B words.
- `busy` is combinational from FSM state and `level`.

## Structure
- Shared package `jit_pkg`:
  - opcode constants `OP_GO`=4'hA, `OP_SW`=4'hB, `OP_ARG`=4'hC;
  - arg-index constants 1..3;
  - FSM state enum.
- Sub-module `jit_cmd_fifo`:
  - synchronous FIFO with `DEPTH` entries, 32-bit data, pointers one bit wider than the address;
  - `level` derived from pointer difference.
- The FSM, filter, and gap counter live in the top module.

## Test plan
- Push C(idx1, 0x1234), C(idx2, 0x0042), A. Required:
  - `cmd` shows 0xC0101234, 0, 0xC0200042, 0, 0xA0000000 on consecutive-eligible cycles;
  - then `cmd` holds 0 until `done` is pulsed 20 cycles later;
  - `busy` drops 1 cycle after `done`.
- Push B(0x0ABCDEF) and B(0x0000001) back-to-back. Required:
  - `sw_cfg_valid` high for 2 consecutive cycles with data 0x0ABCDEF, then 0x0000001;
  - `cmd` never non-zero.
- Push C(idx 0) and 0x00000000, then C(idx3, 0x0007). Required:
  - both bad words dropped and `err`=1;
  - only 0xC0300007 appears on `cmd`.
- Push A, then pulse `done` during the ISSUE_RUN cycle. Required: the pulse is ignored, and the FSM stays in RUN_WAIT until a second `done`.
- Hold `s_cmd_valid` for 10 words with a stalled A at the head (no `done`). Required:
  - `s_cmd_ready` falls once `level`=8;
  - `level` does not exceed 8.
- Assert `ap_rst_n`=0 asynchronously mid-RUN_WAIT with the FIFO at level 5. Required:
  - `cmd`, `level`, `err`, and `busy` clear without waiting for a clock edge;
  - after release, a new C word issues normally.
